// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational ALU between NUM_REQ requesters. A round-robin
//   arbiter picks one request in IDLE, registers its operands towards the ALU
//   (EXEC), registers the ALU result/zero flag (RESP) and holds the tagged
//   response until the consumer takes it. Only one operation is in flight.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake (ready is one-hot or zero)
//   req_op/op1/op2/branch packed request payloads, requester i at [i*W +: W]
//   alu_op/op1/op2/branch registered operands driven to the ALU
//   alu_result/alu_zero   combinational ALU outputs
//   rsp_valid/rsp_ready   response handshake
//   rsp_id/result/zero    registered response (owner index, result, flag)
//
// Optional build macro ALU_ARB_STATS_EN adds stat_grants: one saturating
// 16-bit accept counter per requester.
module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1,
  parameter int OP_W    = 4,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_op1,
  input  logic [NUM_REQ*DATA_W-1:0] req_op2,
  input  logic [NUM_REQ*3-1:0]      req_branch,
  output logic [OP_W-1:0]           alu_op,
  output logic [DATA_W-1:0]         alu_op1,
  output logic [DATA_W-1:0]         alu_op2,
  output logic [2:0]                alu_branch,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      alu_zero,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_zero
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]     stat_grants
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state_q;
  logic [ID_W-1:0]     last_q;
  logic [OP_W-1:0]     alu_op_q;
  logic [DATA_W-1:0]   alu_op1_q;
  logic [DATA_W-1:0]   alu_op2_q;
  logic [2:0]          alu_branch_q;
  logic                rsp_valid_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic [DATA_W-1:0]   rsp_result_q;
  logic                rsp_zero_q;

  // Unpacked views of the request payloads.
  logic [OP_W-1:0]   op_a   [NUM_REQ];
  logic [DATA_W-1:0] op1_a  [NUM_REQ];
  logic [DATA_W-1:0] op2_a  [NUM_REQ];
  logic [2:0]        br_a   [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign op_a[gi]  = req_op[gi*OP_W +: OP_W];
    assign op1_a[gi] = req_op1[gi*DATA_W +: DATA_W];
    assign op2_a[gi] = req_op2[gi*DATA_W +: DATA_W];
    assign br_a[gi]  = req_branch[gi*3 +: 3];
  end

  // Round-robin search starting just after the last granted requester.
  logic [NUM_REQ-1:0] grant_d;
  logic [ID_W-1:0]    win_idx_d;
  logic               win_found_d;

  always_comb begin
    grant_d     = '0;
    win_idx_d   = '0;
    win_found_d = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_found_d && req_valid[(int'(last_q) + k) % NUM_REQ]) begin
        win_found_d = 1'b1;
        win_idx_d   = ID_W'((int'(last_q) + k) % NUM_REQ);
        grant_d[(int'(last_q) + k) % NUM_REQ] = 1'b1;
      end
    end
  end

  // Ready is gated by rst_n so nothing is offered while reset is held.
  assign req_ready = (state_q == IDLE && rst_n) ? grant_d : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_q       <= ID_W'(NUM_REQ - 1);
      alu_op_q     <= '0;
      alu_op1_q    <= '0;
      alu_op2_q    <= '0;
      alu_branch_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found_d) begin
            alu_op_q     <= op_a[win_idx_d];
            alu_op1_q    <= op1_a[win_idx_d];
            alu_op2_q    <= op2_a[win_idx_d];
            alu_branch_q <= br_a[win_idx_d];
            last_q       <= win_idx_d;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          // last_q still names the owner of the operation in flight.
          rsp_result_q <= alu_result;
          rsp_zero_q   <= alu_zero;
          rsp_id_q     <= last_q;
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_op     = alu_op_q;
  assign alu_op1    = alu_op1_q;
  assign alu_op2    = alu_op2_q;
  assign alu_branch = alu_branch_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;

`ifdef ALU_ARB_STATS_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
    logic [15:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (req_valid[gi] && req_ready[gi] && cnt_q != 16'hFFFF) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
    assign stat_grants[gi*16 +: 16] = cnt_q;
  end
`endif

endmodule
